// File: rtl/seg7_pkg.sv
// seg7_pkg: segment pattern constants, BCD marker codes and FSM state type
// shared by the 7-segment encoder and scan-decoder sides.
package seg7_pkg;
   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [3:0] BCD_BLANK = 4'hF;
   localparam logic [3:0] BCD_BAD   = 4'hE;
   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_e;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational 7-segment pattern to BCD decoder.
// Ports: seg_i {a..g} pattern in; legal_o = decimal digit; blank_o = all segments off;
//        bcd_o = digit value, BCD_BLANK for blank, BCD_BAD for anything else.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic       legal_o,
   output logic       blank_o,
   output logic [3:0] bcd_o
);
   always_comb begin
      legal_o = 1'b1;
      blank_o = 1'b0;
      bcd_o   = BCD_BAD;
      case (seg_i)
         SEG_0:     bcd_o = 4'd0;
         SEG_1:     bcd_o = 4'd1;
         SEG_2:     bcd_o = 4'd2;
         SEG_3:     bcd_o = 4'd3;
         SEG_4:     bcd_o = 4'd4;
         SEG_5:     bcd_o = 4'd5;
         SEG_6:     bcd_o = 4'd6;
         SEG_7:     bcd_o = 4'd7;
         SEG_8:     bcd_o = 4'd8;
         SEG_9:     bcd_o = 4'd9;
         SEG_BLANK: begin
            legal_o = 1'b0;
            blank_o = 1'b1;
            bcd_o   = BCD_BLANK;
         end
         default:   legal_o = 1'b0;
      endcase
   end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: reconstructs per-digit BCD values from a multiplexed
// segment/digit-select bus, committing a digit only after its sample is stable.
// Ports: clk_i, reset_i (async, active-high); seg_in_i {a..g}; dig_sel_i one-hot
//        digit enables; err_clr_i clears err_o; bcd_out_o 4 bits per digit;
//        digit_valid_o legal-decimal flag per digit; frame_done_o one-cycle pulse
//        when every digit has committed; err_o sticky illegal-pattern/multi-select flag.
// Optional: SEG7_SCAN_ERR_COUNT_EN adds err_count_o, a saturating error counter.
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [6:0]              seg_in_i,
   input  logic [NUM_DIGITS-1:0]   dig_sel_i,
   input  logic                    err_clr_i,
   output logic [4*NUM_DIGITS-1:0] bcd_out_o,
   output logic [NUM_DIGITS-1:0]   digit_valid_o,
   output logic                    frame_done_o,
   output logic                    err_o
`ifdef SEG7_SCAN_ERR_COUNT_EN
   ,
   output logic [7:0]              err_count_o
`endif
);
   import seg7_pkg::*;
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int SW = NUM_DIGITS + 7;
   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [SW-1:0]           prev_q, smp;
   logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d, seen_q, seen_d, seen_nx;
   logic                    frame_q, frame_d, err_q, err_d;
   logic                    one_hot, multi, same, commit, err_set;
   logic                    dec_legal, dec_blank;
   logic [3:0]              dec_bcd;
   assign smp     = {dig_sel_i, seg_in_i};
   assign one_hot = $onehot(dig_sel_i);
   assign multi   = (|dig_sel_i) & ~one_hot;
   assign same    = smp == prev_q;
   seg7_pattern_decode u_dec (
      .seg_i   (seg_in_i),
      .legal_o (dec_legal),
      .blank_o (dec_blank),
      .bcd_o   (dec_bcd)
   );
   // A held, unchanged sample leaves the counter parked at STABLE_CYCLES.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      if (!one_hot) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (!(state_q == ST_HOLD && same)) begin
         cnt_d   = (state_q == ST_SETTLE && same) ? cnt_q + 1'b1 : CW'(1);
         commit  = cnt_d == CW'(STABLE_CYCLES);
         state_d = commit ? ST_HOLD : ST_SETTLE;
      end
   end
   always_comb begin
      bcd_d   = bcd_q;
      valid_d = valid_q;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (commit && dig_sel_i[i]) begin
            bcd_d[4*i +: 4] = dec_bcd;
            valid_d[i]      = dec_legal;
         end
      seen_nx = seen_q | (commit ? dig_sel_i : '0);
      frame_d = &seen_nx;
      seen_d  = frame_d ? '0 : seen_nx;
      err_set = multi | (commit & ~dec_legal & ~dec_blank);
      err_d   = err_set | (err_q & ~err_clr_i);
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         prev_q  <= '0;
         bcd_q   <= '0;
         valid_q <= '0;
         seen_q  <= '0;
         frame_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prev_q  <= smp;
         bcd_q   <= bcd_d;
         valid_q <= valid_d;
         seen_q  <= seen_d;
         frame_q <= frame_d;
         err_q   <= err_d;
      end
   end
   assign bcd_out_o     = bcd_q;
   assign digit_valid_o = valid_q;
   assign frame_done_o  = frame_q;
   assign err_o         = err_q;
`ifdef SEG7_SCAN_ERR_COUNT_EN
   logic [7:0] ecnt_q, ecnt_d;
   // Bad commits and multi-select samples never coincide, so one step suffices.
   always_comb
      ecnt_d = err_set ? (err_clr_i ? 8'd1 : ((&ecnt_q) ? ecnt_q : ecnt_q + 8'd1))
                       : (err_clr_i ? 8'd0 : ecnt_q);
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) ecnt_q <= '0;
      else         ecnt_q <= ecnt_d;
   assign err_count_o = ecnt_q;
`endif
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed scoreboard bench for seg7_scan_decoder.
module tb_seg7_scan_decoder;
   localparam int ND = 4;
   logic          clk = 1'b0;
   logic          reset, err_clr;
   logic [6:0]    seg;
   logic [ND-1:0] dig;
   logic [4*ND-1:0] bcd;
   logic [ND-1:0] valid;
   logic          frame, err;
   logic [ND-1:0] seen_m;
   int checks = 0, failures = 0;
   string       tag_q[$];
   logic [31:0] exp_q[$];
   always #5 clk = ~clk;
   seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .seg_in_i      (seg),
      .dig_sel_i     (dig),
      .err_clr_i     (err_clr),
      .bcd_out_o     (bcd),
      .digit_valid_o (valid),
      .frame_done_o  (frame),
      .err_o         (err)
   );
   function automatic logic [6:0] enc(int v);
      case (v)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         9: return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction
   task automatic push(string t, logic [31:0] e);
      tag_q.push_back(t);
      exp_q.push_back(e);
   endtask
   task automatic pop_check(logic [31:0] obs);
      string t;
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty: observed %0h expected nothing", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", t, obs, e);
         end
      end
   endtask
   task automatic drive(logic [ND-1:0] d, logic [6:0] s);
      dig = d;
      seg = s;
   endtask
   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      reset = 1'b1; err_clr = 1'b0; dig = '0; seg = '0; seen_m = '0;
      tick(2);
      push("rst_bcd", 0); push("rst_valid", 0); push("rst_frame", 0); push("rst_err", 0);
      pop_check(32'(bcd)); pop_check(32'(valid)); pop_check(32'(frame)); pop_check(32'(err));
      reset = 1'b0;
      // single digit, commit exactly on the 4th edge
      drive(4'b0001, enc(3));
      push("t1_early_valid", 0);
      tick(3); pop_check(32'(valid[0]));
      push("t1_bcd", 3); push("t1_valid", 1);
      tick(1); pop_check(32'(bcd[3:0])); pop_check(32'(valid[0]));
      seen_m |= 4'b0001;
      // toggling pattern must not commit
      push("t2_toggle_nocommit", 0);
      for (int k = 0; k < 2; k++) begin
         drive(4'b0100, enc(5)); tick(2);
         drive(4'b0100, enc(6)); tick(2);
      end
      drive(4'b0100, enc(5)); tick(2);
      pop_check(32'(valid[2]));
      drive(4'b0100, enc(6));
      push("t2_early_valid", 0);
      tick(3); pop_check(32'(valid[2]));
      push("t2_bcd", 6); push("t2_valid", 1);
      tick(1); pop_check(32'(bcd[11:8])); pop_check(32'(valid[2]));
      seen_m |= 4'b0100;
      // full frame scan
      for (int d = 0; d < ND; d++) begin
         drive(ND'(1 << d), enc(d + 1));
         push("t3_frame_pre", 0);
         tick(3); pop_check(32'(frame));
         seen_m |= ND'(1 << d);
         push("t3_frame_commit", 32'(&seen_m));
         if (&seen_m) seen_m = '0;
         tick(1); pop_check(32'(frame));
      end
      push("t3_bcd", 32'h4321); push("t3_valid", 32'hF);
      pop_check(32'(bcd)); pop_check(32'(valid));
      push("t3_frame_one_cycle", 0);
      tick(1); pop_check(32'(frame));
      // multi-select fault and err_clr
      push("t4_err_before", 0); pop_check(32'(err));
      drive(4'b0011, enc(8));
      push("t4_err_set", 1); push("t4_no_commit", 32'h4321);
      tick(1); pop_check(32'(err)); pop_check(32'(bcd));
      drive(4'b0000, enc(8)); tick(1);
      err_clr = 1'b1; tick(1); err_clr = 1'b0;
      push("t4_err_cleared", 0); pop_check(32'(err));
      drive(4'b0011, enc(8)); err_clr = 1'b1;
      push("t4_set_wins", 1);
      tick(1); err_clr = 1'b0; pop_check(32'(err));
      drive(4'b0000, enc(8)); err_clr = 1'b1;
      push("t4_err_cleared2", 0);
      tick(1); err_clr = 1'b0; pop_check(32'(err));
      // blank pattern
      drive(4'b0010, 7'b0000000);
      push("t5_bcd", 32'h43F1); push("t5_valid", 32'hD); push("t5_err", 0);
      tick(4); pop_check(32'(bcd)); pop_check(32'(valid)); pop_check(32'(err));
      seen_m |= 4'b0010;
      // illegal pattern
      drive(4'b0010, 7'b1001001);
      push("t6_err_early", 0);
      tick(3); pop_check(32'(err));
      push("t6_bcd", 32'hE); push("t6_valid", 0); push("t6_err", 1);
      tick(1); pop_check(32'(bcd[7:4])); pop_check(32'(valid[1])); pop_check(32'(err));
      // asynchronous reset mid-settle
      drive(4'b0001, enc(8));
      tick(2);
      #2 reset = 1'b1;
      push("t7_rst_bcd", 0); push("t7_rst_valid", 0); push("t7_rst_frame", 0); push("t7_rst_err", 0);
      #1;
      pop_check(32'(bcd)); pop_check(32'(valid)); pop_check(32'(frame)); pop_check(32'(err));
      seen_m = '0;
      tick(1); reset = 1'b0;
      push("t7_partial_discarded", 0);
      tick(3); pop_check(32'(valid[0]));
      seen_m |= 4'b0001;
      push("t7_bcd", 8); push("t7_valid", 1); push("t7_frame", 32'(&seen_m));
      tick(1); pop_check(32'(bcd[3:0])); pop_check(32'(valid[0])); pop_check(32'(frame));
      if (exp_q.size() != 0) begin
         failures++;
         $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
